// File: rtl/multicycle_adder_pkg.sv
// multicycle_adder_pkg: FSM state type and mode encodings shared by the multicycle adder.
package multicycle_adder_pkg;
  typedef enum logic [1:0] {IDLE, ADD, WRAP, DONE} state_t;
  localparam logic MODE_TWOS = 1'b0;
  localparam logic MODE_ONES = 1'b1;
endpackage

// File: rtl/multicycle_adder_slice.sv
// adder_slice: combinational W-bit adder with carry in and carry out.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: chunk-serial adder, two's or ones' complement with end-around carry.
// Define MULTICYCLE_ADDER_OVF_EN to add the signed-overflow output.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy
`ifdef MULTICYCLE_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  state_t state, next;
  logic [WIDTH-1:0] a_r, b_r, res;
  logic mode_r, carry, cin, cout, last;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] sa, sb, sum;
  // WRAP reuses the slice to ripple the end-around 1 through the result
  assign sa = state == WRAP ? res[idx*CHUNK +: CHUNK] : a_r[idx*CHUNK +: CHUNK];
  assign sb = state == WRAP ? '0 : b_r[idx*CHUNK +: CHUNK];
  assign cin = state == WRAP ? 1'b1 : carry;
  assign last = idx == IW'(NCHUNK - 1);
  assign result = res;
  adder_slice #(.W(CHUNK)) u_slice (.a(sa), .b(sb), .cin(cin), .sum(sum), .cout(cout));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (in_valid ? ADD : IDLE)
         : state == ADD  ? (last ? ((mode_r == MODE_ONES && cout) ? WRAP : DONE) : ADD)
         : state == WRAP ? ((!cout || last) ? DONE : WRAP)
         : (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = state == IDLE;
    busy = state != IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      mode_r <= MODE_TWOS;
      carry <= 1'b0;
      idx <= '0;
      res <= '0;
      carry_out <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
        mode_r <= mode;
        carry <= 1'b0;
        idx <= '0;
      end
    end else if (state == ADD || state == WRAP) begin
      res[idx*CHUNK +: CHUNK] <= sum;
      carry <= cout;
      idx <= last ? '0 : idx + IW'(1);
      if (state == ADD && last) carry_out <= cout;
    end
`ifdef MULTICYCLE_ADDER_OVF_EN
  assign overflow = out_valid & (a_r[WIDTH-1] == b_r[WIDTH-1]) & (res[WIDTH-1] != a_r[WIDTH-1]);
`endif
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: randomized scoreboard bench for multicycle_adder (WIDTH=16, CHUNK=4).
module tb_multicycle_adder;
  logic clk = 0, rst = 1, in_valid = 0, mode = 0, out_ready = 0;
  logic in_ready, out_valid, carry_out, busy;
  logic [15:0] a = 0, b = 0, result;
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic overflow;
`endif
  typedef struct {
    logic [15:0] r;
    logic c;
    logic ov;
    int lat;
    int acc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, n_checks = 0, n_fail = 0, lat_meas = 0;
  bit rr_en = 0, hold_ready = 0, seen = 0, prev_stall = 0;
  logic [15:0] prev_res;
  logic prev_co;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .busy(busy)
`ifdef MULTICYCLE_ADDER_OVF_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic m);
    logic [16:0] s;
    int k;
    exp_t e;
    s = {1'b0, x} + {1'b0, y};
    e.c = s[16];
    e.r = s[15:0];
    e.lat = 4;
    e.acc = 0;
    if (m && s[16]) begin
      k = 1;
      while (k < 4 && ((int'(s[15:0]) & ((1 << (4 * k)) - 1)) == (1 << (4 * k)) - 1)) k++;
      e.r = s[15:0] + 16'd1;
      e.lat = 4 + k;
    end
    e.ov = (x[15] == y[15]) && (e.r[15] != x[15]);
    return e;
  endfunction

  // called at posedge+#1; accept happens at the next edge where in_ready is seen
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic m, input bit push);
    int t = 0;
    exp_t e;
    in_valid = 1; a = x; b = y; mode = m;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    e = model(x, y, m);
    e.acc = cyc + 1;
    if (push) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 0; a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin @(posedge clk); t++; end
    chk("drain", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    out_ready = rr_en ? ($urandom_range(0, 3) != 0) : hold_ready;
    if (rst) begin
      seen = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", 32'(result), 32'(prev_res));
        chk("hold_carry", 32'(carry_out), 32'(prev_co));
      end
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        else begin
          if (!seen) begin seen = 1; lat_meas = cyc - q[0].acc; end
          if (out_ready) begin
            chk("result", 32'(result), 32'(q[0].r));
            chk("carry_out", 32'(carry_out), 32'(q[0].c));
            chk("latency", 32'(lat_meas), 32'(q[0].lat));
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
`ifdef MULTICYCLE_ADDER_OVF_EN
            chk("overflow", 32'(overflow), 32'(q[0].ov));
`endif
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res = result;
      prev_co = carry_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    rst = 0;
    rr_en = 1;
    @(posedge clk); #1;
    send(16'h1234, 16'h4321, 0, 1);
    send(16'hFFFF, 16'h0001, 0, 1);
    send(16'h8FFF, 16'h8000, 1, 1);
    send(16'h8000, 16'h7FFF, 1, 1);
    send(16'hFFFE, 16'h0003, 1, 1);
    send(16'hFFFF, 16'hFFFF, 1, 1);
    drain();
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    // stall in DONE while in_valid pulses with other operands
    rr_en = 0; hold_ready = 0;
    send(16'h1111, 16'h2222, 0, 1);
    for (int t = 0; t < 50 && !out_valid; t++) begin @(posedge clk); #1; end
    chk("stall_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    hold_ready = 1;
    send(16'h0F0F, 16'h0101, 1, 1);
    drain();
    rr_en = 1;
    // reset during the second ADD cycle
    in_valid = 1; a = 16'h1234; b = 16'h4321; mode = 0;
    chk("pre_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_carry", 32'(carry_out), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(16'h7FFF, 16'h0001, 0, 1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
